data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  Byte-addressable data memory for the RISC-V datapath, successor to the single-word LW/SW memory.
//  Supports LB/LH/LW/LBU/LHU loads and SB/SH/SW stores with byte-lane writes, sign/zero extension and alignment checking.
//  Uses a req/rsp handshake with programmable read latency so the pipeline can stall on memory.
//  Sits between the ALU address output and the write-back mux.
// PARAMETERS
//  DM_ADDRESS  9   byte-address width; the memory holds 2**(DM_ADDRESS-2) 32-bit words
//  DATA_W      32  data width; the only supported value is 32
//  READ_LAT    1   clock cycles from load accept to rsp_valid; legal range 1..4
// PORTS
//  clk        in   1           clock; all state updates on the rising edge
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   1           request present
//  req_ready  out  1           block can accept a request
//  MemRead    in   1           request is a load
//  MemWrite   in   1           request is a store
//  Address    in   DM_ADDRESS  byte address
//  WD         in   DATA_W      store data, right-aligned
//  Funct3     in   3           instruction bits 14:12, selecting access size and signedness
//  rsp_valid  out  1           response pulse, one cycle wide
//  RD         out  DATA_W      load data, already extended
//  rsp_err    out  1           access rejected; no memory side effect
// BEHAVIOUR
//  - Reset: req_ready=1, rsp_valid=0, RD=0, rsp_err=0, FSM=IDLE, latency counter=0. Memory contents are not cleared.
//  - Accept: a request is accepted when req_valid && req_ready. req_ready is high only in IDLE.
//  - FSM states and transitions:
//    - IDLE -> WAIT on an accepted load.
//    - IDLE -> RESP on an accepted store or an error.
//    - WAIT -> RESP after READ_LAT-1 further cycles. With READ_LAT=1, WAIT is skipped.
//    - RESP asserts rsp_valid for one cycle, then returns to IDLE.
//  - Latency: a load gives rsp_valid exactly READ_LAT cycles after the accept edge. A store or error gives rsp_valid 1 cycle after accept.
//  - Request fields are captured at accept and may change afterwards.
//  - Word index is Address[DM_ADDRESS-1:2]; byte offset is Address[1:0].
//  - Stores write on the accept edge:
//    - SB: byte lane = offset, data = WD[7:0].
//    - SH: lanes {off+1, off}, data = WD[15:0].
//    - SW: all four lanes.
//    - Unselected lanes are unchanged.
//  - Loads select the byte or halfword at the offset.
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//    - The read array is sampled at accept, so a store accepted earlier is always visible.
//  - Errors set rsp_err=1 with RD=0, and no write occurs:
//    - halfword access with Address[0]=1
//    - word access with Address[1:0]!=0
//    - load Funct3 values 011/110/111, or store Funct3 values >=011
//    - MemRead && MemWrite both high
//  - Request with neither MemRead nor MemWrite: accepted as a no-op, rsp_valid after 1 cycle, rsp_err=0, RD=0.
//  - RD and rsp_err hold their values until the next response. Both are 0 on a store response.
//  - Reset mid-operation aborts the pending load with no response. A store already accepted stays written.
// CONFIGURATION
//  - DMEM_OUT_REG_EN defined:
//    - Adds an output register stage: rsp_valid, RD and rsp_err come 1 cycle later, so load latency is READ_LAT+1 and store latency is 2.
//    - req_ready stays low until the response has been issued.
//  - DMEM_OUT_REG_EN undefined: latencies are exactly as given in BEHAVIOUR.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> RD=0xDEADBEEF, rsp_err=0, rsp_valid READ_LAT cycles after accept.
//  2. After test 1: SB 0x5A @0x11, then LBU @0x11 -> 0x0000005A; LB @0x13 -> 0xFFFFFFDE; LW @0x10 -> 0xDEAD5AEF.
//  3. SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001; word @0x20 lanes 0-1 unchanged.
//  4. LW @0x12, SH @0x21, and MemRead=MemWrite=1 -> each gives rsp_err=1, RD=0; a following LW shows memory unchanged.
//  5. READ_LAT=3: back-to-back LW requests -> req_ready low for 3 cycles after each accept, one rsp_valid per request, in order.
//  6. Assert reset during WAIT of a load -> no rsp_valid, req_ready=1 the cycle after reset, earlier store data intact.

Source files
------------

// File: rtl/data_memory_lsu.sv
// ---------------------------------------------------------------------------
// data_memory_lsu
//   Byte-addressable data memory with a load/store unit front end.
//   Handles LB/LH/LW/LBU/LHU loads and SB/SH/SW stores, with byte-lane
//   writes, sign/zero extension and alignment checking. A req/rsp handshake
//   with a programmable read latency lets the pipeline stall on memory.
//
//   Build option:
//     DMEM_OUT_REG_EN  adds a register stage on rsp_valid/RD/rsp_err. Every
//                      response then arrives one cycle later, and req_ready
//                      stays low until that delayed response has gone out.
//
//   Ports:
//     clk        clock, rising edge
//     reset      synchronous, active-high reset
//     req_valid  request present
//     req_ready  block can accept a request (high only in IDLE)
//     MemRead    request is a load
//     MemWrite   request is a store
//     Address    byte address
//     WD         store data, right-aligned
//     Funct3     access size / signedness (instruction bits 14:12)
//     rsp_valid  one-cycle response pulse
//     RD         load data, already extended; holds until the next response
//     rsp_err    access rejected, no memory side effect
//
//   States:
//     IDLE  waiting for a request, req_ready high
//     WAIT  load accepted, counting down the remaining read latency
//     RESP  rsp_valid is high for this cycle
//     OUTQ  response is in the output register stage (DMEM_OUT_REG_EN only)
// ---------------------------------------------------------------------------
module data_memory_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] Address,
    input  logic [DATA_W-1:0]     WD,
    input  logic [2:0]            Funct3,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     RD,
    output logic                  rsp_err
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
    // WAIT is entered with the number of extra WAIT cycles still to spend
    localparam logic [1:0] LAT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        OUTQ = 2'd3
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [1:0]        lat_cnt;
    logic [DATA_W-1:0] ld_data;
    logic              core_valid;
    logic [DATA_W-1:0] core_rd;
    logic              core_err;

    logic                  accept;
    logic [DM_ADDRESS-3:0] word_idx;
    logic [1:0]            offset;
    logic                  misaligned;
    logic                  bad_ld_f3;
    logic                  bad_st_f3;
    logic                  req_err;
    logic                  do_write;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     load_ext;
    logic [3:0]            byte_en;
    logic [DATA_W-1:0]     wlane;
    logic [DATA_W-1:0]     merged;

    // ------------------------------------------------------------------
    // Request decode, load extraction and store lane merge
    // ------------------------------------------------------------------
    always_comb begin
        accept     = req_valid && req_ready;
        word_idx   = Address[DM_ADDRESS-1:2];
        offset     = Address[1:0];

        misaligned = ((Funct3[1:0] == 2'b01) && Address[0]) ||
                     ((Funct3[1:0] == 2'b10) && (offset != 2'b00));
        bad_ld_f3  = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
        bad_st_f3  = (Funct3 >= 3'b011);

        req_err    = (MemRead && MemWrite) ||
                     (MemRead  && (bad_ld_f3 || misaligned)) ||
                     (MemWrite && (bad_st_f3 || misaligned));

        // gated by reset so a store colliding with reset leaves memory alone
        do_write   = accept && MemWrite && !req_err && !reset;

        rd_word    = mem[word_idx];
        shifted    = rd_word >> {offset, 3'b000};

        load_ext = '0;
        case (Funct3)
            3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = rd_word;
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = '0;
        endcase

        byte_en = 4'b0000;
        wlane   = WD;
        case (Funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << offset;
                wlane   = {4{WD[7:0]}};
            end
            2'b01: begin
                byte_en = 4'b0011 << offset;
                wlane   = {2{WD[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wlane   = WD;
            end
            default: begin
                byte_en = 4'b0000;
                wlane   = WD;
            end
        endcase

        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = wlane[8*i +: 8];
            end
        end
    end

    // Memory is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[word_idx] <= merged;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            lat_cnt    <= 2'd0;
            ld_data    <= '0;
            core_valid <= 1'b0;
            core_rd    <= '0;
            core_err   <= 1'b0;
        end else begin
            core_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (MemRead && !req_err) begin
                            // the array is read here, so the data reflects
                            // every store accepted before this load
                            if (READ_LAT == 1) begin
                                state      <= RESP;
                                core_valid <= 1'b1;
                                core_rd    <= load_ext;
                                core_err   <= 1'b0;
                            end else begin
                                state   <= WAIT;
                                lat_cnt <= LAT_INIT;
                                ld_data <= load_ext;
                            end
                        end else begin
                            // store, no-op or rejected access
                            state      <= RESP;
                            core_valid <= 1'b1;
                            core_rd    <= '0;
                            core_err   <= req_err;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        state      <= RESP;
                        core_valid <= 1'b1;
                        core_rd    <= ld_data;
                        core_err   <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
`ifdef DMEM_OUT_REG_EN
                    state <= OUTQ;
`else
                    state     <= IDLE;
                    req_ready <= 1'b1;
`endif
                end
                OUTQ: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------
`ifdef DMEM_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            RD        <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= core_valid;
            if (core_valid) begin
                RD      <= core_rd;
                rsp_err <= core_err;
            end
        end
    end
`else
    assign rsp_valid = core_valid;
    assign RD        = core_rd;
    assign rsp_err   = core_err;
`endif

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

    localparam int LAT = 3;
`ifdef DMEM_OUT_REG_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  Address;
    logic [31:0] WD;
    logic [2:0]  Funct3;
    logic        rsp_valid;
    logic [31:0] RD;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    data_memory_lsu #(
        .DM_ADDRESS(9),
        .DATA_W    (32),
        .READ_LAT  (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Address  (Address),
        .WD       (WD),
        .Funct3   (Funct3),
        .rsp_valid(rsp_valid),
        .RD       (RD),
        .rsp_err  (rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [8:0] addr,
                                input logic [31:0] wd, input logic [2:0] f3,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.f3 = f3;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic scramble();
        req_valid = 1'b0;
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        Address   = 9'($urandom);
        WD        = $urandom;
        Funct3    = 3'($urandom);
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle again.
    task automatic do_req(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        int   cyc;
        int   lat;
        int   ready_low;
        int   pulses;
        bit   seen_ready;
        bit   done;
        e.rd  = v.exp_rd;
        e.err = v.exp_err;
        e.lat = (v.rd && !v.wr && !v.exp_err) ? LAT + XTRA : 1 + XTRA;

        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            chk({tag, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
            return;
        end

        req_valid = 1'b1;
        MemRead   = v.rd;
        MemWrite  = v.wr;
        Address   = v.addr;
        WD        = v.wd;
        Funct3    = v.f3;
        sb.push_back(e);
        @(posedge clk);
        #1 scramble();

        lat = 0; ready_low = 0; pulses = 0; seen_ready = 0; done = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = c;
                    if (sb.size() == 0) begin
                        chk({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
                    end else begin
                        got = sb.pop_front();
                        chk({tag, "_rd"},  RD, got.rd);
                        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, got.err});
                        chk({tag, "_lat"}, lat, got.lat);
                    end
                end
            end
            if (!seen_ready) begin
                if (req_ready) seen_ready = 1;
                else           ready_low++;
            end
            if (pulses > 0 && c == lat + 1) begin
                chk({tag, "_rd_hold"}, RD, e.rd);
            end
            if (pulses > 0 && seen_ready && c >= lat + 1) done = 1;
        end
        if (pulses == 0) begin
            chk({tag, "_rsp_timeout"}, {31'd0, rsp_valid}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        chk({tag, "_pulses"},    pulses,    1);
        chk({tag, "_ready_low"}, ready_low, e.lat);
    endtask

    initial begin
        int n_rsp;

        // {rd, wr, addr, wd, f3, exp_rd, exp_err}
        tbl.push_back(mk(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0,        0)); // SW
        tbl.push_back(mk(1, 0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0)); // LW
        tbl.push_back(mk(0, 1, 9'h011, 32'hFFFFFF5A, 3'b000, 32'h0,        0)); // SB
        tbl.push_back(mk(1, 0, 9'h011, 32'h0,        3'b100, 32'h0000005A, 0)); // LBU
        tbl.push_back(mk(1, 0, 9'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 0)); // LB
        tbl.push_back(mk(1, 0, 9'h010, 32'h0,        3'b010, 32'hDEAD5AEF, 0)); // LW
        tbl.push_back(mk(1, 0, 9'h010, 32'h0,        3'b000, 32'hFFFFFFEF, 0)); // LB
        tbl.push_back(mk(1, 0, 9'h012, 32'h0,        3'b100, 32'h000000AD, 0)); // LBU
        tbl.push_back(mk(1, 0, 9'h010, 32'h0,        3'b001, 32'h00005AEF, 0)); // LH
        tbl.push_back(mk(1, 0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 0)); // LH
        tbl.push_back(mk(0, 1, 9'h020, 32'h12345678, 3'b010, 32'h0,        0)); // SW
        tbl.push_back(mk(0, 1, 9'h022, 32'hABCD8001, 3'b001, 32'h0,        0)); // SH
        tbl.push_back(mk(1, 0, 9'h022, 32'h0,        3'b001, 32'hFFFF8001, 0)); // LH
        tbl.push_back(mk(1, 0, 9'h022, 32'h0,        3'b101, 32'h00008001, 0)); // LHU
        tbl.push_back(mk(1, 0, 9'h020, 32'h0,        3'b010, 32'h80015678, 0)); // LW
        tbl.push_back(mk(1, 0, 9'h012, 32'h0,        3'b010, 32'h0,        1)); // LW misaligned
        tbl.push_back(mk(0, 1, 9'h021, 32'h0000FFFF, 3'b001, 32'h0,        1)); // SH misaligned
        tbl.push_back(mk(1, 1, 9'h020, 32'hFFFFFFFF, 3'b010, 32'h0,        1)); // rd+wr
        tbl.push_back(mk(0, 1, 9'h020, 32'hFFFFFFFF, 3'b011, 32'h0,        1)); // bad store f3
        tbl.push_back(mk(1, 0, 9'h020, 32'h0,        3'b110, 32'h0,        1)); // bad load f3
        tbl.push_back(mk(1, 0, 9'h020, 32'h0,        3'b010, 32'h80015678, 0)); // LW unchanged
        tbl.push_back(mk(0, 0, 9'h020, 32'hFFFFFFFF, 3'b010, 32'h0,        0)); // no-op
        tbl.push_back(mk(0, 1, 9'h023, 32'h00000077, 3'b000, 32'h0,        0)); // SB lane 3
        tbl.push_back(mk(1, 0, 9'h020, 32'h0,        3'b010, 32'h77015678, 0)); // LW
        tbl.push_back(mk(1, 0, 9'h021, 32'h0,        3'b000, 32'h00000056, 0)); // LB
        tbl.push_back(mk(1, 0, 9'h023, 32'h0,        3'b000, 32'h00000077, 0)); // LB

        reset = 1'b1;
        scramble();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rd",        RD,                 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            do_req(tbl[i], $sformatf("v%0d", i));
        end

        // Reset while a load sits in WAIT: the load is dropped silently.
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        Address   = 9'h010;
        Funct3    = 3'b010;
        @(posedge clk);
        #1 scramble();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        n_rsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        chk("abort_no_rsp", n_rsp, 0);

        do_req(mk(1, 0, 9'h010, 32'h0, 3'b010, 32'hDEAD5AEF, 0), "post_rst_lw10");
        do_req(mk(1, 0, 9'h020, 32'h0, 3'b010, 32'h77015678, 0), "post_rst_lw20");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
